// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: freeze/flush/bubble control of the
// IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// Latency: all controls are combinational from the current inputs and FSM state;
//   a multi-cycle memory access holds the whole pipe for MEM_LATENCY-1 cycles.
// Backpressure: stall_all freezes everything behind IF; RAW hazards freeze IF/ID
//   and bubble ID/EX; taken branches flush IF/ID and bubble ID/EX.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   id_*                      source operands / valid of the instruction in ID
//   exe_wb_en, exe_dest       writeback info of the ID/EX register output
//   mem_wb_en, mem_dest       writeback info of the EX/MEM register output
//   mem_r_en, mem_w_en        memory access in the MEM stage
//   exe_branch                taken branch in EX
//   cnt_clr                   clear of the performance counters
//   if_freeze, if_flush, id_bubble, stall_all, mem_done   pipeline controls
//   stall_cycles, flush_count saturating performance counters
module pipe_hazard_ctrl #(
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic             id_valid,
  input  logic             exe_wb_en,
  input  logic [3:0]       exe_dest,
  input  logic             mem_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             exe_branch,
  input  logic             cnt_clr,
  output logic             if_freeze,
  output logic             if_flush,
  output logic             id_bubble,
  output logic             stall_all,
  output logic             mem_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  // The first cycle of an access is spent in RUN, so the wait counter only
  // has to cover the remaining MEM_LATENCY-1 cycles (last one at wcnt==0).
  localparam int         WAIT_INIT_I = (MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0;
  localparam logic [3:0] WAIT_INIT   = 4'(WAIT_INIT_I);
  localparam bit         MULTI_CYCLE = (MEM_LATENCY > 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state, state_nxt;
  logic [3:0] wcnt, wcnt_nxt;
  logic       mem_op;
  logic       hz;
  logic       fl;

  assign mem_op = mem_r_en | mem_w_en;

  // Memory wait-state FSM
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    stall_all = 1'b0;
    mem_done  = 1'b0;
    case (state)
      RUN: begin
        if (mem_op) begin
          if (MULTI_CYCLE) begin
            stall_all = 1'b1;
            state_nxt = MEM_WAIT;
            wcnt_nxt  = WAIT_INIT;
          end else begin
            mem_done = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        if (wcnt != 4'd0) begin
          stall_all = 1'b1;
          wcnt_nxt  = wcnt - 4'd1;
        end else begin
          // Pipe advances on this edge, so the same op is not seen again in RUN.
          mem_done  = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (rst) begin
      stall_all = 1'b0;
      mem_done  = 1'b0;
    end
  end

  // RAW hazard against EX and MEM producers; no forwarding paths exist.
  always_comb begin
    hz = id_valid & ~rst &
         ((exe_wb_en & (exe_dest == id_src1)) |
          (mem_wb_en & (mem_dest == id_src1)) |
          (id_two_src & ((exe_wb_en & (exe_dest == id_src2)) |
                         (mem_wb_en & (mem_dest == id_src2)))));
  end

  // A branch held in EX by stall_all waits there and flushes once unstalled.
  assign fl = exe_branch & ~stall_all & ~rst;

  // Priority: stall_all > flush > hazard. Under stall_all ID/EX is frozen,
  // so it must not be bubbled.
  always_comb begin
    if_flush  = fl;
    id_bubble = ~stall_all & (fl | hz);
    if_freeze = stall_all | (~fl & hz);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      wcnt         <= 4'd0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (cnt_clr) begin
        stall_cycles <= '0;
        flush_count  <= '0;
      end else begin
        if (if_freeze && (stall_cycles != '1))
          stall_cycles <= stall_cycles + CNT_ONE;
        if (if_flush && (flush_count != '1))
          flush_count <= flush_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: dut_a (MEM_LATENCY=4, 16-bit counters) and dut_b
// (MEM_LATENCY=1, 4-bit counters) are driven from directed vectors; each vector
// pushes its expected controls and counter values, a monitor pops and compares.
// Control vectors are {if_freeze, if_flush, id_bubble, stall_all, mem_done}.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_two_src;
    logic       id_valid;
    logic       exe_wb_en;
    logic [3:0] exe_dest;
    logic       mem_wb_en;
    logic [3:0] mem_dest;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       exe_branch;
  } in_t;

  typedef struct packed {
    logic [4:0]  ca;
    logic [4:0]  cb;
    logic [15:0] sa;
    logic [15:0] fa;
    logic [3:0]  sb;
    logic [3:0]  fb;
    logic [15:0] idx;
  } exp_t;

  localparam logic [4:0] C_IDLE  = 5'b00000;
  localparam logic [4:0] C_HZ    = 5'b10100;
  localparam logic [4:0] C_STALL = 5'b10010;
  localparam logic [4:0] C_DONE  = 5'b00001;
  localparam logic [4:0] C_FL    = 5'b01100;
  localparam logic [4:0] C_FLD   = 5'b01101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst, cnt_clr;
  in_t   ia, ib;
  logic  a_frz, a_fl, a_bub, a_stall, a_done;
  logic  b_frz, b_fl, b_bub, b_stall, b_done;
  logic [15:0] a_sc, a_fc;
  logic [3:0]  b_sc, b_fc;

  exp_t q[$];
  int checks = 0;
  int passed = 0;
  int sa = 0, fa = 0, sb = 0, fb = 0;
  int step_no = 0;

  pipe_hazard_ctrl #(.MEM_LATENCY(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .id_src1(ia.id_src1), .id_src2(ia.id_src2), .id_two_src(ia.id_two_src),
    .id_valid(ia.id_valid), .exe_wb_en(ia.exe_wb_en), .exe_dest(ia.exe_dest),
    .mem_wb_en(ia.mem_wb_en), .mem_dest(ia.mem_dest), .mem_r_en(ia.mem_r_en),
    .mem_w_en(ia.mem_w_en), .exe_branch(ia.exe_branch), .cnt_clr(cnt_clr),
    .if_freeze(a_frz), .if_flush(a_fl), .id_bubble(a_bub), .stall_all(a_stall),
    .mem_done(a_done), .stall_cycles(a_sc), .flush_count(a_fc)
  );

  pipe_hazard_ctrl #(.MEM_LATENCY(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .id_src1(ib.id_src1), .id_src2(ib.id_src2), .id_two_src(ib.id_two_src),
    .id_valid(ib.id_valid), .exe_wb_en(ib.exe_wb_en), .exe_dest(ib.exe_dest),
    .mem_wb_en(ib.mem_wb_en), .mem_dest(ib.mem_dest), .mem_r_en(ib.mem_r_en),
    .mem_w_en(ib.mem_w_en), .exe_branch(ib.exe_branch), .cnt_clr(cnt_clr),
    .if_freeze(b_frz), .if_flush(b_fl), .id_bubble(b_bub), .stall_all(b_stall),
    .mem_done(b_done), .stall_cycles(b_sc), .flush_count(b_fc)
  );

  function automatic in_t hz_ex();
    in_t t = '0;
    t.id_valid  = 1'b1;
    t.id_src1   = 4'd3;
    t.exe_wb_en = 1'b1;
    t.exe_dest  = 4'd3;
    return t;
  endfunction

  function automatic in_t two_src(input logic two, input logic vld);
    in_t t = '0;
    t.id_valid   = vld;
    t.id_src1    = 4'd1;
    t.id_src2    = 4'd5;
    t.id_two_src = two;
    t.mem_wb_en  = 1'b1;
    t.mem_dest   = 4'd5;
    return t;
  endfunction

  function automatic in_t mem_acc(input logic rd, input logic br);
    in_t t = '0;
    t.mem_r_en   = rd;
    t.mem_w_en   = ~rd;
    t.exe_branch = br;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask

  // Drive one cycle of inputs and queue what the DUTs must show during it.
  // Counter expectations come from a saturating model fed by the expected
  // controls, updated as of the coming clock edge.
  task automatic step(input logic r, input logic clr, input in_t a, input in_t b,
                      input logic [4:0] ea, input logic [4:0] eb);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; cnt_clr = clr; ia = a; ib = b;
    e.ca = ea; e.cb = eb;
    e.sa = 16'(sa); e.fa = 16'(fa); e.sb = 4'(sb); e.fb = 4'(fb);
    e.idx = 16'(step_no);
    q.push_back(e);
    step_no++;
    if (r || clr) begin
      sa = 0; fa = 0; sb = 0; fb = 0;
    end else begin
      if (ea[4] && sa < 65535) sa++;
      if (ea[3] && fa < 65535) fa++;
      if (eb[4] && sb < 15) sb++;
      if (eb[3] && fb < 15) fb++;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ctl_a", int'(e.idx), {11'd0, a_frz, a_fl, a_bub, a_stall, a_done}, {11'd0, e.ca});
        chk("ctl_b", int'(e.idx), {11'd0, b_frz, b_fl, b_bub, b_stall, b_done}, {11'd0, e.cb});
        chk("stall_cycles_a", int'(e.idx), a_sc, e.sa);
        chk("flush_count_a", int'(e.idx), a_fc, e.fa);
        chk("stall_cycles_b", int'(e.idx), {12'd0, b_sc}, {12'd0, e.sb});
        chk("flush_count_b", int'(e.idx), {12'd0, b_fc}, {12'd0, e.fb});
      end
    end
  end

  initial begin : driver
    in_t z;
    z = '0;
    rst = 1'b1; cnt_clr = 1'b0; ia = '0; ib = '0;
    repeat (2) @(posedge clk);

    // Reset gates every control even with a hazard and a load presented
    begin
      in_t t;
      t = hz_ex();
      t.mem_r_en = 1'b1;
      step(1, 0, t, t, C_IDLE, C_IDLE);
    end

    // RAW on EX result
    step(0, 0, hz_ex(), z, C_HZ, C_IDLE);
    step(0, 0, z, z, C_IDLE, C_IDLE);

    // Second source only counts when id_two_src is set and ID is valid
    step(0, 0, two_src(0, 1), z, C_IDLE, C_IDLE);
    step(0, 0, two_src(1, 1), z, C_HZ, C_IDLE);
    step(0, 0, two_src(1, 0), z, C_IDLE, C_IDLE);

    // Load, then back-to-back load: 3 stall cycles then mem_done each
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 3; i++) step(0, 0, mem_acc(1, 0), z, C_STALL, C_IDLE);
      step(0, 0, mem_acc(1, 0), z, C_DONE, C_IDLE);
    end
    step(0, 0, z, z, C_IDLE, C_IDLE);

    // Branch held in EX across a store wait: flush only on the done cycle
    for (int i = 0; i < 3; i++) step(0, 0, mem_acc(0, 1), z, C_STALL, C_IDLE);
    step(0, 0, mem_acc(0, 1), z, C_FLD, C_IDLE);
    step(0, 0, z, z, C_IDLE, C_IDLE);

    // Branch beats hazard
    begin
      in_t t;
      t = hz_ex();
      t.exe_branch = 1'b1;
      step(0, 0, t, z, C_FL, C_IDLE);
    end

    // Reset in MEM_WAIT with wcnt=2: access aborted, no mem_done afterwards
    step(0, 0, mem_acc(1, 0), z, C_STALL, C_IDLE);
    step(1, 0, mem_acc(1, 0), z, C_IDLE, C_IDLE);
    step(0, 0, z, z, C_IDLE, C_IDLE);
    step(0, 0, z, z, C_IDLE, C_IDLE);

    // Single-cycle memory: done every op cycle, never stalls
    step(0, 0, z, mem_acc(1, 0), C_IDLE, C_DONE);
    step(0, 0, z, mem_acc(0, 0), C_IDLE, C_DONE);

    // Saturate 4-bit counters, then clear wins over a concurrent increment
    for (int i = 0; i < 17; i++) step(0, 0, z, hz_ex(), C_IDLE, C_HZ);
    begin
      in_t t;
      t = '0;
      t.exe_branch = 1'b1;
      for (int i = 0; i < 17; i++) step(0, 0, z, t, C_IDLE, C_FL);
    end
    step(0, 1, z, hz_ex(), C_IDLE, C_HZ);
    step(0, 0, z, z, C_IDLE, C_IDLE);
    step(0, 0, z, z, C_IDLE, C_IDLE);

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", step_no, 16'(q.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
